// File: rtl/mem_arbiter_fill_ctrl.sv
// Unified memory port arbiter and multi-word block fill sequencer for I/D caches.
// Define MEM_ARB_PERF_CNT_EN to add saturating per-cache fill completion counters.
module mem_arbiter_fill_ctrl #(
  parameter int ADDR_W = 16,
  parameter int WORDS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              I_miss,
  input  logic [ADDR_W-1:0] I_addr,
  input  logic              D_miss,
  input  logic [ADDR_W-1:0] D_addr,
  input  logic              D_wr_req,
  input  logic [ADDR_W-1:0] D_wr_data,
  input  logic [ADDR_W-1:0] mem_data_out,
  input  logic              mem_data_valid,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_data_in,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [ADDR_W-1:0] fill_data,
  output logic              I_data_we,
  output logic              I_tag_we,
  output logic              D_data_we,
  output logic              D_tag_we,
  output logic              I_stall,
  output logic              D_stall,
  output logic              busy,
  output logic [15:0]       I_fill_cnt,
  output logic [15:0]       D_fill_cnt
);

  localparam int CW = $clog2(WORDS) + 1;
  localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'(2 * WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    I_FILL,
    D_FILL,
    D_WRITE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]     ret_cnt_q, ret_cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] issue_off, ret_off;
  logic              data_we, tag_we;

  assign issue_off = ADDR_W'({issue_cnt_q, 1'b0});
  assign ret_off   = ADDR_W'({ret_cnt_q, 1'b0});

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    base_d      = base_q;
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_data_in = '0;
    fill_addr   = '0;
    fill_data   = '0;
    data_we     = 1'b0;
    tag_we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (I_miss) begin
          base_d      = I_addr & ~BLK_MASK;
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
          state_d     = I_FILL;
        end else if (D_miss) begin
          base_d      = D_addr & ~BLK_MASK;
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
          state_d     = D_FILL;
        end else if (D_wr_req) begin
          state_d = D_WRITE;
        end
      end
      I_FILL, D_FILL: begin
        if (issue_cnt_q < CW'(WORDS)) begin
          mem_en      = 1'b1;
          mem_addr    = base_q + issue_off;
          issue_cnt_d = issue_cnt_q + CW'(1);
        end
        // Returns may overlap issues; the last one also validates the tag.
        if (mem_data_valid) begin
          fill_addr = base_q + ret_off;
          fill_data = mem_data_out;
          data_we   = 1'b1;
          ret_cnt_d = ret_cnt_q + CW'(1);
          if (ret_cnt_q == CW'(WORDS - 1)) begin
            tag_we  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      D_WRITE: begin
        mem_en      = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = D_addr;
        mem_data_in = D_wr_data;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      base_q      <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      base_q      <= base_d;
    end
  end

  assign I_data_we = data_we & (state_q == I_FILL);
  assign I_tag_we  = tag_we & (state_q == I_FILL);
  assign D_data_we = data_we & (state_q == D_FILL);
  assign D_tag_we  = tag_we & (state_q == D_FILL);

  assign busy    = (state_q != IDLE);
  assign I_stall = (state_q == I_FILL) | ((state_q == IDLE) & I_miss);
  assign D_stall = ((D_miss | D_wr_req) & (state_q != D_WRITE))
                 | (state_q == D_FILL);

`ifdef MEM_ARB_PERF_CNT_EN
  logic [15:0] i_cnt_q, i_cnt_d;
  logic [15:0] d_cnt_q, d_cnt_d;

  always_comb begin
    i_cnt_d = i_cnt_q;
    d_cnt_d = d_cnt_q;
    if (I_tag_we && (i_cnt_q != 16'hFFFF)) i_cnt_d = i_cnt_q + 16'd1;
    if (D_tag_we && (d_cnt_q != 16'hFFFF)) d_cnt_d = d_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_cnt_q <= '0;
      d_cnt_q <= '0;
    end else begin
      i_cnt_q <= i_cnt_d;
      d_cnt_q <= d_cnt_d;
    end
  end

  assign I_fill_cnt = i_cnt_q;
  assign D_fill_cnt = d_cnt_q;
`else
  assign I_fill_cnt = 16'h0000;
  assign D_fill_cnt = 16'h0000;
`endif

endmodule

// File: doc/mem_arbiter_fill_ctrl.md
Name: mem_arbiter_fill_ctrl

Overview:
- Owns the single unified-memory port that is shared by the I-cache and the D-cache.
- Arbitrates between three request sources: I-cache miss fills, D-cache miss fills, and D-cache write-through stores.
- Sequences multi-word block fills: issues read addresses to memory, collects the returned words, and drives the cache data and tag write enables.
- Generates per-cache stall signals for the pipeline.

Parameters:
- ADDR_W, 16, address and data width in bits.
- WORDS, 8, 16-bit words per cache block (block = 2*WORDS bytes); must be a power of 2.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- I_miss  in  1  I-cache miss; held until the fill completes.
- I_addr  in  ADDR_W  byte address that missed in the I-cache.
- D_miss  in  1  D-cache miss (load).
- D_addr  in  ADDR_W  D-side byte address, for both miss and store.
- D_wr_req  in  1  store request; held until serviced.
- D_wr_data  in  ADDR_W  store data.
- mem_data_out  in  ADDR_W  read data returned by memory.
- mem_data_valid  in  1  mem_data_out is valid this cycle.
- mem_en  out  1  memory access this cycle.
- mem_wr  out  1  write access; only valid when mem_en=1.
- mem_addr  out  ADDR_W  memory address.
- mem_data_in  out  ADDR_W  memory write data.
- fill_addr  out  ADDR_W  cache word address being filled.
- fill_data  out  ADDR_W  word written into the cache (= mem_data_out).
- I_data_we  out  1  I-cache data array write enable.
- I_tag_we  out  1  I-cache tag/valid write enable.
- D_data_we  out  1  D-cache data array write enable.
- D_tag_we  out  1  D-cache tag/valid write enable.
- I_stall  out  1  stall the fetch stage.
- D_stall  out  1  stall the memory stage.
- busy  out  1  state != IDLE.
- I_fill_cnt  out  16  I fills completed (see Optional Feature).
- D_fill_cnt  out  16  D fills completed (see Optional Feature).

Behaviour:
- States: IDLE, I_FILL, D_FILL, D_WRITE.
- Reset: state=IDLE; issue_cnt=0, ret_cnt=0; base=0. All outputs are 0 except those derived combinationally from I_miss, D_miss or D_wr_req as defined below.
- IDLE priority: I_miss > D_miss > D_wr_req.
  - I_miss or D_miss: latch base = addr & ~(2*WORDS-1), clear both counters, go to the matching FILL state.
  - D_wr_req only: go to D_WRITE.
- FILL issue phase:
  - While issue_cnt < WORDS: mem_en=1, mem_wr=0, mem_addr = base + 2*issue_cnt; issue_cnt increments every cycle.
  - The first issue is in the cycle after leaving IDLE.
  - Consecutive cycles are pipelined with no gaps.
- FILL return phase:
  - Each cycle with mem_data_valid=1: fill_addr = base + 2*ret_cnt, fill_data = mem_data_out, the active cache's data_we=1, ret_cnt increments.
  - Returns may overlap the issue phase.
  - On the WORDS-th return, tag_we=1 in the same cycle as the last data_we; next state = IDLE.
- Fill latency: with a memory of fixed read latency L, the last data_we occurs (WORDS-1+L) cycles after the first issue.
- D_WRITE (one cycle): mem_en=1, mem_wr=1, mem_addr=D_addr, mem_data_in=D_wr_data; next state = IDLE.
  - The D-cache data write on a store hit is the D-cache's own responsibility; this block does not pulse D_data_we for stores.
- Idle memory outputs: mem_en=0, mem_wr=0; mem_addr and mem_data_in are don't-care.
- mem_data_valid in IDLE or D_WRITE: ignored, no enables asserted.
- Stalls:
  - I_stall = (state==I_FILL) | (state==IDLE & I_miss).
  - D_stall = (D_miss|D_wr_req) & ~(state==D_WRITE) | (state==D_FILL).
  - Both stalls drop in the cycle the cache hits, i.e. the cycle after tag_we.
- Simultaneous I_miss and D_miss: the I fill runs first. D_miss stays high, and the D fill starts in the IDLE cycle after the I fill completes.
- Miss deasserted mid-fill: the fill still completes, including the tag write.
- Reset mid-fill: returns to IDLE immediately; no tag_we is issued, so the block stays invalid. The memory must be reset by the same rst, so that no stale returns arrive.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- Defined: I_fill_cnt and D_fill_cnt increment on each I_tag_we and D_tag_we respectively. Both saturate at 16'hFFFF and reset to 0.
- Undefined: both outputs are tied to 16'h0000 and no counter flops exist.

Test Plan:
- I_miss=1, I_addr=16'h1236, memory latency 4 ->
  - mem_addr sequence 16'h1230..16'h123E over 8 consecutive cycles;
  - I_data_we for 8 cycles starting 4 cycles after the first issue;
  - I_tag_we with the last word (fill_addr=16'h123E);
  - I_stall low once I_miss drops.
- I_miss and D_miss asserted in the same cycle (I_addr=16'h0040, D_addr=16'h8010) ->
  - complete I fill of 16'h0040..16'h004E;
  - one IDLE cycle;
  - then D fill of 16'h8010..16'h801E;
  - D_stall high throughout.
- D_wr_req=1, D_addr=16'h2002, D_wr_data=16'hBEEF in IDLE ->
  - next cycle mem_en=1, mem_wr=1, mem_addr=16'h2002, mem_data_in=16'hBEEF;
  - back to IDLE the following cycle.
- Assert rst after the 3rd returned word of a D fill ->
  - state IDLE, no D_tag_we, all enables 0;
  - a new I_miss afterwards fills normally.
- mem_data_valid pulsed while IDLE -> no data_we or tag_we asserted.
- With MEM_ARB_PERF_CNT_EN: 3 I fills and 2 D fills -> I_fill_cnt=3, D_fill_cnt=2.
- Without MEM_ARB_PERF_CNT_EN: both counters remain 0.
